// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, fixed programmable access latency,
// response held under backpressure, out-of-range addresses flagged and never written.
module data_mem_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 65536,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_we,
    output logic              rsp_err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "data_mem_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_en_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_we_q, rsp_we_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              enter_resp;
    logic              mem_wr;
    logic [IdxW-1:0]   idx;

    assign in_range   = 32'(addr_q) < DEPTH;
    assign idx        = addr_q[IdxW-1:0];
    assign enter_resp = (state_q == StBusy) && (cnt_q == 4'd0);
    assign mem_wr     = enter_resp && we_q && in_range;

    // ready_en_q keeps req_ready low until the first edge after reset release.
    assign req_ready  = (state_q == StIdle) && ready_en_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_we     = rsp_we_q;
    assign rsp_err    = rsp_err_q;

    // Every latency value, including 1, passes through BUSY so rsp_valid
    // always rises exactly LATENCY edges after the accept edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StResp;
                    rsp_we_d    = we_q;
                    rsp_err_d   = !in_range;
                    rsp_rdata_d = (!we_q && in_range) ? mem[idx] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_we_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            ready_en_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_en_q  <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage is deliberately not reset; contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array model
// with a response scoreboard.
module tb_data_mem_responder;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 3;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_we;
    logic              rsp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    data_mem_responder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_we   (rsp_we),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: a word array of DEPTH entries; anything beyond is an error.
    task automatic model_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                                output rsp_t r);
        r.we = we;
        if (int'(addr) >= int'(DEPTH)) begin
            r.err   = 1'b1;
            r.rdata = 32'h0;
        end else begin
            r.err = 1'b0;
            if (we) begin
                model[int'(addr)] = wd;
                r.rdata = 32'h0;
            end else begin
                r.rdata = model.exists(int'(addr)) ? model[int'(addr)] : 32'h0;
            end
        end
    endtask

    // One complete transaction; lat is -1 if the response never appeared.
    task automatic xact(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        output int lat, output rsp_t r);
        int w;
        lat = -1;
        r   = '0;
        w   = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        if (lat >= 0) begin
            r.we      = rsp_we;
            r.err     = rsp_err;
            r.rdata   = rsp_rdata;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 0", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_we, rsp_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rsp_flags: got %b want 000", {rsp_valid, rsp_we, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 00000000", rsp_rdata);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready_early: got %b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_store();
        rsp_t exp, got;
        int   lat;
        model_access(1'b1, 16'h0010, 32'hDEADBEEF, exp);
        xact(1'b1, 16'h0010, 32'hDEADBEEF, lat, got);
        checks++;
        if (lat !== int'(LATENCY)) begin
            errors++;
            $display("FAIL store_latency: got %0d want %0d", lat, LATENCY);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL store_rsp: got we=%b err=%b rdata=%h want we=%b err=%b rdata=%h",
                     got.we, got.err, got.rdata, exp.we, exp.err, exp.rdata);
        end
    endtask

    task automatic test_load();
        rsp_t exp, got;
        int   lat;
        model_access(1'b0, 16'h0010, 32'h0, exp);
        xact(1'b0, 16'h0010, 32'h0, lat, got);
        checks++;
        if (lat !== int'(LATENCY)) begin
            errors++;
            $display("FAIL load_latency: got %0d want %0d", lat, LATENCY);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL load_rsp: got we=%b err=%b rdata=%h want we=%b err=%b rdata=%h",
                     got.we, got.err, got.rdata, exp.we, exp.err, exp.rdata);
        end
    endtask

    task automatic test_backpressure();
        rsp_t exp, snap, cur;
        int   lat;
        model_access(1'b0, 16'h0010, 32'h0, exp);
        @(negedge clk);
        req_we    = 1'b0;
        req_addr  = 16'h0010;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 40 && !rsp_valid; n++) @(negedge clk);
        snap = {rsp_we, rsp_err, rsp_rdata};
        checks++;
        if (!rsp_valid || snap !== exp) begin
            errors++;
            $display("FAIL hold_first: got valid=%b rdata=%h want valid=1 rdata=%h",
                     rsp_valid, snap.rdata, exp.rdata);
        end
        // Junk stores offered while stalled must never be taken.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 16'h0010;
            req_wdata = $urandom;
            cur = {rsp_we, rsp_err, rsp_rdata};
            checks++;
            if (rsp_valid !== 1'b1 || cur !== snap || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b ready=%b rdata=%h want 1 0 %h",
                         rsp_valid, req_ready, cur.rdata, snap.rdata);
            end
        end
        @(negedge clk);
        req_we    = 1'b0;
        req_addr  = 16'h0010;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_ready: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        cur = {rsp_we, rsp_err, rsp_rdata};
        checks++;
        if (lat !== int'(LATENCY) || cur !== exp) begin
            errors++;
            $display("FAIL queued_req: got lat=%0d rdata=%h want lat=%0d rdata=%h",
                     lat, cur.rdata, LATENCY, exp.rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        rsp_t exp, got;
        int   lat;
        model_access(1'b1, 16'h0000, 32'h0BADF00D, exp);
        xact(1'b1, 16'h0000, 32'h0BADF00D, lat, got);
        model_access(1'b1, 16'h0400, 32'h12345678, exp);
        xact(1'b1, 16'h0400, 32'h12345678, lat, got);
        checks++;
        if (got !== exp || lat !== int'(LATENCY)) begin
            errors++;
            $display("FAIL oor_store: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                     got.err, got.rdata, lat, exp.err, exp.rdata, LATENCY);
        end
        model_access(1'b0, 16'h0400, 32'h0, exp);
        xact(1'b0, 16'h0400, 32'h0, lat, got);
        checks++;
        if (got !== exp || lat !== int'(LATENCY)) begin
            errors++;
            $display("FAIL oor_load: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                     got.err, got.rdata, lat, exp.err, exp.rdata, LATENCY);
        end
        model_access(1'b0, 16'h0000, 32'h0, exp);
        xact(1'b0, 16'h0000, 32'h0, lat, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL oor_alias: got err=%b rdata=%h want err=%b rdata=%h",
                     got.err, got.rdata, exp.err, exp.rdata);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t exp, got;
        int   lat;
        model_access(1'b1, 16'h0020, 32'h11111111, exp);
        xact(1'b1, 16'h0020, 32'h11111111, lat, got);
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 32'hA5A5A5A5;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata} !== 36'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got ready=%b valid=%b we=%b err=%b rdata=%h want 0",
                     req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        model_access(1'b0, 16'h0020, 32'h0, exp);
        xact(1'b0, 16'h0020, 32'h0, lat, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midreset_data: got rdata=%h want %h", got.rdata, exp.rdata);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t        q[$];
        rsp_t        exp, cur;
        int          sent, got;
        logic        acc, acc_prev;
        logic [15:0] pair_addr;
        sent      = 0;
        got       = 0;
        acc_prev  = 1'b0;
        pair_addr = '0;
        for (int c = 0; c < 3000 && got < 16; c++) begin
            @(negedge clk);
            if (acc_prev) req_valid = 1'b0;
            if (!req_valid && sent < 16) begin
                if (sent % 2 == 0) begin
                    pair_addr = 16'($urandom_range(0, DEPTH + 63));
                    req_we    = 1'b1;
                end else begin
                    req_we = 1'b0;
                end
                req_wdata = $urandom;
                req_addr  = pair_addr;
                req_valid = 1'b1;
                sent++;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            acc = req_valid && req_ready;
            if (rsp_valid && rsp_ready) begin
                cur = {rsp_we, rsp_err, rsp_rdata};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: got rdata=%h with nothing outstanding", cur.rdata);
                end else begin
                    exp = q.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL b2b_rsp%0d: got we=%b err=%b rdata=%h want we=%b err=%b rdata=%h",
                                 got, cur.we, cur.err, cur.rdata, exp.we, exp.err, exp.rdata);
                    end
                end
                got++;
            end
            if (acc) begin
                model_access(req_we, req_addr, req_wdata, exp);
                q.push_back(exp);
            end
            acc_prev = acc;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checks++;
        if (got !== 16 || q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses (%0d pending) want 16 (0)", got, q.size());
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_extra: got rsp_valid=%b want 0", rsp_valid);
            end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
